// File: rtl/demux_stream_n.sv
// Registered 1-to-NCH stream demultiplexer with broadcast.
// Each channel is a one-entry valid/ready register; invalid selects are dropped and counted.

module demux_stream_n_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             free,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  // Free also when draining this cycle, so a refill needs no bubble.
  assign free = ~valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux_stream_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [SELW-1:0]      S,
  input  logic                 bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 sel_err,
  output logic [7:0]           drop_cnt
);
  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic           sel_ok;
  logic           accept;
  logic           drop;
  logic [NCH-1:0] sel_oh;
  logic [NCH-1:0] free;
  logic [NCH-1:0] load;

  assign sel_ok = ({1'b0, S} < NCH_L);

  // Broadcast is all-or-nothing; an out-of-range select is always accepted and dropped.
  always_comb begin
    in_ready = 1'b1;
    if (bcast)       in_ready = &free;
    else if (sel_ok) in_ready = |(free & sel_oh);
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~bcast & ~sel_ok;
  assign load   = {NCH{accept}} & ({NCH{bcast}} | sel_oh);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign sel_oh[k] = sel_ok && (S == SELW'(k));

    demux_stream_n_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .d     (A),
      .ready (out_ready[k]),
      .free  (free[k]),
      .data  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: directed scenarios on a 4-channel build, drops and
// randomized scoreboard traffic on a 3-channel build.
module tb_demux_stream_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-channel build
  logic [7:0]  a4 = '0;
  logic [1:0]  s4 = '0;
  logic        b4 = 1'b0, iv4 = 1'b0, ir4, se4;
  logic [31:0] od4;
  logic [3:0]  ov4, or4 = '0;
  logic [7:0]  dc4;

  // 3-channel build (select value 3 is invalid)
  logic [7:0]  a3 = '0;
  logic [1:0]  s3 = '0;
  logic        b3 = 1'b0, iv3 = 1'b0, ir3, se3;
  logic [23:0] od3;
  logic [2:0]  ov3, or3 = '0;
  logic [7:0]  dc3;

  demux_stream_n dut4 (
    .clk(clk), .rst(rst), .A(a4), .S(s4), .bcast(b4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .sel_err(se4), .drop_cnt(dc4)
  );

  demux_stream_n #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .A(a3), .S(s3), .bcast(b3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .sel_err(se3), .drop_cnt(dc3)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ov4 !== 4'b0) begin bad++; $display("FAIL reset_ov4 got=%b exp=0000", ov4); end
    total++; if (od4 !== 32'h0) begin bad++; $display("FAIL reset_od4 got=%h exp=0", od4); end
    total++; if (se4 !== 1'b0 || dc4 !== 8'd0) begin bad++; $display("FAIL reset_err4 got se=%b dc=%0d exp 0/0", se4, dc4); end
    total++; if (ov3 !== 3'b0 || dc3 !== 8'd0) begin bad++; $display("FAIL reset_dut3 got ov=%b dc=%0d exp 0/0", ov3, dc3); end
    rst = 1'b0;
  endtask

  task automatic test_unicast;
    @(negedge clk); a4 = 8'hA5; s4 = 2'd2; iv4 = 1'b1; or4 = 4'b0;
    @(negedge clk);
    total++; if (ov4 !== 4'b0100) begin bad++; $display("FAIL uni_valid got=%b exp=0100", ov4); end
    total++; if (od4[23:16] !== 8'hA5) begin bad++; $display("FAIL uni_data got=%h exp=a5", od4[23:16]); end
    a4 = 8'h77;
    #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL uni_full_ready got=%b exp=0", ir4); end
    @(negedge clk); iv4 = 1'b0;
    total++; if (od4[23:16] !== 8'hA5 || ov4 !== 4'b0100) begin bad++; $display("FAIL uni_hold got=%h/%b exp=a5/0100", od4[23:16], ov4); end
  endtask

  task automatic test_drain_refill;
    @(negedge clk); or4 = 4'b0100; a4 = 8'h3C; s4 = 2'd2; iv4 = 1'b1;
    #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL refill_ready got=%b exp=1", ir4); end
    @(negedge clk); iv4 = 1'b0; or4 = 4'b0;
    total++; if (ov4 !== 4'b0100 || od4[23:16] !== 8'h3C) begin bad++; $display("FAIL refill_data got=%b/%h exp=0100/3c", ov4, od4[23:16]); end
  endtask

  task automatic test_bcast;
    @(negedge clk); s4 = 2'd1; a4 = 8'h11; iv4 = 1'b1;
    @(negedge clk); iv4 = 1'b0;
    total++; if (ov4 !== 4'b0110) begin bad++; $display("FAIL bc_setup got=%b exp=0110", ov4); end
    b4 = 1'b1; a4 = 8'h5A; iv4 = 1'b1;
    #1;
    total++; if (ir4 !== 1'b0) begin bad++; $display("FAIL bc_blocked_ready got=%b exp=0", ir4); end
    @(negedge clk);
    total++; if (ov4 !== 4'b0110 || od4[15:8] !== 8'h11 || od4[7:0] !== 8'h00) begin bad++; $display("FAIL bc_partial got=%b/%h exp=0110/00001100", ov4, od4[15:0]); end
    or4 = 4'b0110;
    #1;
    total++; if (ir4 !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", ir4); end
    @(negedge clk); iv4 = 1'b0; b4 = 1'b0; or4 = 4'b0;
    total++; if (ov4 !== 4'b1111 || od4 !== 32'h5A5A5A5A) begin bad++; $display("FAIL bc_all got=%b/%h exp=1111/5a5a5a5a", ov4, od4); end
  endtask

  task automatic test_drop;
    @(negedge clk); s3 = 2'd3; a3 = 8'hFF; b3 = 1'b0; iv3 = 1'b1;
    #1;
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", ir3); end
    @(negedge clk); iv3 = 1'b0;
    total++; if (se3 !== 1'b1 || dc3 !== 8'd1 || ov3 !== 3'b0) begin bad++; $display("FAIL drop_first got se=%b dc=%0d ov=%b exp 1/1/000", se3, dc3, ov3); end
    @(negedge clk);
    total++; if (se3 !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b exp=0", se3); end
    iv3 = 1'b1;
    repeat (255) @(negedge clk);
    iv3 = 1'b0;
    total++; if (dc3 !== 8'd0 || se3 !== 1'b1) begin bad++; $display("FAIL drop_wrap got dc=%0d se=%b exp 0/1", dc3, se3); end
    @(negedge clk);
    total++; if (se3 !== 1'b0 || ov3 !== 3'b0) begin bad++; $display("FAIL drop_end got se=%b ov=%b exp 0/000", se3, ov3); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk); or4 = 4'b0100; s3 = 2'd3; iv3 = 1'b1;
    @(negedge clk); or4 = 4'b0; iv3 = 1'b0;
    total++; if (ov4 !== 4'b1011 || dc3 !== 8'd1) begin bad++; $display("FAIL mid_setup got ov=%b dc3=%0d exp 1011/1", ov4, dc3); end
    #2 rst = 1'b1;
    #1;
    total++; if (ov4 !== 4'b0 || od4 !== 32'h0) begin bad++; $display("FAIL mid_async got ov=%b od=%h exp 0/0", ov4, od4); end
    total++; if (dc3 !== 8'd0) begin bad++; $display("FAIL mid_dropcnt got=%0d exp=0", dc3); end
    @(negedge clk); rst = 1'b0; s4 = 2'd0; a4 = 8'hC3; iv4 = 1'b1;
    @(negedge clk); iv4 = 1'b0;
    total++; if (ov4 !== 4'b0001 || od4[7:0] !== 8'hC3) begin bad++; $display("FAIL mid_after got=%b/%h exp=0001/c3", ov4, od4[7:0]); end
    or4 = 4'b1111;
    @(negedge clk); or4 = 4'b0;
    total++; if (ov4 !== 4'b0) begin bad++; $display("FAIL mid_drain got=%b exp=0000", ov4); end
  endtask

  // Scoreboard: per-channel FIFOs of words accepted but not yet consumed.
  task automatic test_random;
    logic [7:0] q [3][$];
    int acc = 0, cyc = 0, drain = 0, drops = 0;
    logic prev_drop = 1'b0;
    logic exp_ir, all_free, tgt;
    while (cyc < 20000 && (acc < 1000 || drain < 3)) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (ov3[k] !== (q[k].size() != 0)) begin bad++; $display("FAIL rnd_valid ch%0d cyc%0d got=%b exp=%b", k, cyc, ov3[k], q[k].size() != 0); end
        if (q[k].size() != 0) begin
          total++;
          if (od3[k*8 +: 8] !== q[k][0]) begin bad++; $display("FAIL rnd_data ch%0d cyc%0d got=%h exp=%h", k, cyc, od3[k*8 +: 8], q[k][0]); end
        end
      end
      total++; if (se3 !== prev_drop) begin bad++; $display("FAIL rnd_sel_err cyc%0d got=%b exp=%b", cyc, se3, prev_drop); end
      total++; if (dc3 !== 8'(drops)) begin bad++; $display("FAIL rnd_drop_cnt cyc%0d got=%0d exp=%0d", cyc, dc3, drops % 256); end
      if (acc < 1000) begin
        a3 = 8'($urandom); s3 = 2'($urandom_range(0, 3));
        b3 = ($urandom_range(0, 7) == 0); iv3 = ($urandom_range(0, 3) != 0);
        or3 = 3'($urandom);
      end else begin
        iv3 = 1'b0; b3 = 1'b0; or3 = 3'b111; drain++;
      end
      #1;
      all_free = 1'b1;
      for (int k = 0; k < 3; k++) if (q[k].size() != 0 && !or3[k]) all_free = 1'b0;
      if (b3)          exp_ir = all_free;
      else if (s3 < 3) exp_ir = (q[s3].size() == 0) || or3[s3];
      else             exp_ir = 1'b1;
      total++; if (ir3 !== exp_ir) begin bad++; $display("FAIL rnd_in_ready cyc%0d got=%b exp=%b", cyc, ir3, exp_ir); end
      for (int k = 0; k < 3; k++) if (q[k].size() != 0 && or3[k]) void'(q[k].pop_front());
      prev_drop = 1'b0;
      if (iv3 && exp_ir) begin
        acc++;
        if (!b3 && s3 == 3) begin drops++; prev_drop = 1'b1; end
        for (int k = 0; k < 3; k++) begin
          tgt = b3 || (s3 == k);
          if (tgt) q[k].push_back(a3);
        end
      end
      cyc++;
    end
    iv3 = 1'b0; or3 = 3'b0;
    total++; if (acc < 1000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=1000", acc); end
    @(negedge clk);
    total++; if (ov3 !== 3'b0) begin bad++; $display("FAIL rnd_final_empty got=%b exp=000", ov3); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_drain_refill();
    test_bcast();
    test_drop();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
